tl_instruction_fetch: RTL and testbench
=======================================

// Module: tl_instruction_fetch
// PURPOSE
//  Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of tl_instruction_decode.
//  Holds PC, word-addressed program memory (loadable via write port), PC+4 adder and IF/ID register.
//  Honours decode stall, branch/jump redirect (inserts NOP bubble) and a HALT opcode FSM.
// PARAMETERS
//  LEN          32             datapath / PC width
//  MEM_DEPTH    256            program memory depth in words
//  NB_MEM_ADDR  $clog2(MEM_DEPTH)  word-index width
//  HALT_OPCODE  6'b111111      opcode (instr[31:26]) that halts fetch
// PORTS
//  i_clk          in   1            clock, all state updates on posedge
//  i_rst          in   1            reset, synchronous, active-low
//  i_enable       in   1            step/run enable from debug unit; 0 freezes entire stage
//  i_flag_stall   in   1            load-use stall from decode; hold PC and IF/ID
//  i_branch       in   1            taken branch, redirect to i_branch_addr
//  i_branch_addr  in   LEN          branch target (byte address)
//  i_jump         in   1            jump, redirect to i_jump_addr
//  i_jump_addr    in   LEN          jump target (byte address)
//  i_mem_wr_en    in   1            program-memory write strobe
//  i_mem_wr_addr  in   NB_MEM_ADDR  word index to write
//  i_mem_wr_data  in   LEN          instruction word to write
//  o_instruccion  out  LEN          IF/ID instruction (to decode i_instruccion)
//  o_adder_pc     out  LEN          IF/ID PC+4 (to decode i_adder_pc)
//  o_pc           out  LEN          current PC (debug)
//  o_halt         out  1            1 while FSM in HALTED
// BEHAVIOUR
//  - Reset (i_rst==0 at posedge): pc=0, o_instruccion=0 (NOP), o_adder_pc=0, state=RUN, o_halt=0.
//    Reset wins over every other input; memory contents NOT cleared.
//  - Fetch: instr = mem[pc[NB_MEM_ADDR+1:2]], combinational read; pc[1:0] and upper bits ignored
//    (address wraps modulo MEM_DEPTH). pc_plus4 = pc+4, modulo 2^LEN.
//  - Memory write: on posedge when i_mem_wr_en, regardless of i_enable/state; same-cycle read of
//    that word returns OLD data.
//  - Priority per posedge (i_rst==1): !i_enable > redirect > HALTED > stall > normal.
//    !i_enable : pc, IF/ID, state all hold.
//    redirect (i_jump | i_branch): pc <= i_jump ? i_jump_addr : i_branch_addr (jump wins if both);
//      IF/ID <= {NOP, 0}; state <= RUN. Overrides stall and HALTED (halt was wrong-path).
//    HALTED    : pc holds; IF/ID <= {NOP, 0}.
//    stall     : pc and IF/ID hold.
//    normal    : IF/ID <= {instr, pc_plus4}; if instr[31:26]==HALT_OPCODE then pc holds and
//      state <= HALTED (halt word enters IF/ID exactly once), else pc <= pc_plus4.
//  - Halt fetched while stalled: not latched yet, no state change until stall drops.
//  - FSM: RUN -> HALTED on halt fetch (normal case); HALTED -> RUN only on redirect or reset.
//  - Latency: instruction at pc appears on o_instruccion 1 posedge after fetch; redirect target
//    word appears 2 posedges after redirect asserted (1 bubble).
//  - o_pc = pc register; o_halt = (state==HALTED), registered.
// TESTING
//  1 Load mem[0..3]=0x20010005,0x20020007,0x00221820,0xFC000000; run -> o_instruccion sequence
//    those words, o_adder_pc 4,8,12,16; o_halt=1 after 4th posedge, pc holds 0xC, then NOPs.
//  2 Stall high 2 cycles at pc=8 -> pc stays 8, o_instruccion/o_adder_pc unchanged 2 cycles,
//    resumes with mem[2] next.
//  3 i_branch=1, addr=0x40 at pc=0x10 -> next o_instruccion=0, pc=0x40; following mem[16].
//  4 i_jump and i_branch same cycle (0x80 vs 0x40) with stall=1 -> pc=0x80, IF/ID=NOP.
//  5 HALTED then i_branch to 0x20 -> o_halt=0, fetch resumes at mem[8].
//  6 i_rst=0 mid-run with i_enable=0 -> pc=0, outputs 0, o_halt=0; memory keeps program;
//    i_enable=0 alone -> all state frozen.

Source files
------------

// File: rtl/tl_instruction_fetch.sv
// Instruction-fetch stage: PC register, word-addressed program memory with
// write port, PC+4 adder, IF/ID pipeline register and HALT state machine.
module tl_instruction_fetch #(
    parameter int unsigned LEN         = 32,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned NB_MEM_ADDR = $clog2(MEM_DEPTH),
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_enable,
    input  logic                   i_flag_stall,
    input  logic                   i_branch,
    input  logic [LEN-1:0]         i_branch_addr,
    input  logic                   i_jump,
    input  logic [LEN-1:0]         i_jump_addr,
    input  logic                   i_mem_wr_en,
    input  logic [NB_MEM_ADDR-1:0] i_mem_wr_addr,
    input  logic [LEN-1:0]         i_mem_wr_data,
    output logic [LEN-1:0]         o_instruccion,
    output logic [LEN-1:0]         o_adder_pc,
    output logic [LEN-1:0]         o_pc,
    output logic                   o_halt
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t         state;
    logic [LEN-1:0] pc;
    logic [LEN-1:0] instr_q;
    logic [LEN-1:0] adder_q;
    logic           halt_q;

    logic [LEN-1:0] mem [MEM_DEPTH];
    logic [LEN-1:0] instr;
    logic [LEN-1:0] pc_plus4;
    logic           redirect;

    // Fetch path: asynchronous word read, byte offset and upper PC bits ignored
    always_comb begin
        instr    = mem[pc[NB_MEM_ADDR+1:2]];
        pc_plus4 = pc + LEN'(4);
        redirect = i_jump | i_branch;
    end

    // Program memory load port, independent of enable, state and reset
    always_ff @(posedge i_clk) begin
        if (i_mem_wr_en) begin
            mem[i_mem_wr_addr] <= i_mem_wr_data;
        end
    end

    // PC, IF/ID register and HALT FSM with fixed update priority
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            pc      <= '0;
            instr_q <= '0;
            adder_q <= '0;
            state   <= ST_RUN;
            halt_q  <= 1'b0;
        end else if (!i_enable) begin
            pc      <= pc;
        end else if (redirect) begin
            // A redirect squashes the fetched word and also cancels a wrong-path halt
            pc      <= i_jump ? i_jump_addr : i_branch_addr;
            instr_q <= '0;
            adder_q <= '0;
            state   <= ST_RUN;
            halt_q  <= 1'b0;
        end else if (state == ST_HALTED) begin
            instr_q <= '0;
            adder_q <= '0;
        end else if (i_flag_stall) begin
            pc      <= pc;
        end else begin
            instr_q <= instr;
            adder_q <= pc_plus4;
            if (instr[LEN-1:LEN-6] == HALT_OPCODE) begin
                state  <= ST_HALTED;
                halt_q <= 1'b1;
            end else begin
                pc <= pc_plus4;
            end
        end
    end

    // Registered outputs
    always_comb begin
        o_instruccion = instr_q;
        o_adder_pc    = adder_q;
        o_pc          = pc;
        o_halt        = halt_q;
    end

endmodule

// File: tb/tb_tl_instruction_fetch.sv
// Self-checking bench for tl_instruction_fetch: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the stage.
module tb_tl_instruction_fetch;

    localparam int unsigned LEN   = 32;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned NBA   = 8;
    localparam logic [31:0] HALTW = 32'hFC00_0000;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            stall;
    logic            br;
    logic [LEN-1:0]  br_addr;
    logic            jmp;
    logic [LEN-1:0]  jmp_addr;
    logic            wr_en;
    logic [NBA-1:0]  wr_addr;
    logic [LEN-1:0]  wr_data;
    logic [LEN-1:0]  instruccion;
    logic [LEN-1:0]  adder_pc;
    logic [LEN-1:0]  pc;
    logic            halt;

    // Behavioural model state
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc;
    logic [31:0] m_ins;
    logic [31:0] m_add;
    bit          m_halted;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tl_instruction_fetch #(
        .LEN(LEN),
        .MEM_DEPTH(DEPTH),
        .NB_MEM_ADDR(NBA),
        .HALT_OPCODE(6'b111111)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_enable(en),
        .i_flag_stall(stall),
        .i_branch(br),
        .i_branch_addr(br_addr),
        .i_jump(jmp),
        .i_jump_addr(jmp_addr),
        .i_mem_wr_en(wr_en),
        .i_mem_wr_addr(wr_addr),
        .i_mem_wr_data(wr_data),
        .o_instruccion(instruccion),
        .o_adder_pc(adder_pc),
        .o_pc(pc),
        .o_halt(halt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b1; en = 1'b1; stall = 1'b0;
        br = 1'b0; br_addr = '0; jmp = 1'b0; jmp_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    endtask

    // Advance one clock: model the stage from the rules, then compare all outputs
    task automatic cycle();
        logic [31:0] f;
        f = m_mem[m_pc[9:2]];
        if (!rst) begin
            m_pc = 0; m_ins = 0; m_add = 0; m_halted = 0;
        end else if (!en) begin
            // frozen
        end else if (jmp || br) begin
            m_pc = jmp ? jmp_addr : br_addr;
            m_ins = 0; m_add = 0; m_halted = 0;
        end else if (m_halted) begin
            m_ins = 0; m_add = 0;
        end else if (stall) begin
            // held
        end else begin
            m_ins = f;
            m_add = m_pc + 32'd4;
            if (f[31:26] == 6'h3F) m_halted = 1;
            else m_pc = m_pc + 32'd4;
        end
        if (wr_en) m_mem[wr_addr] = wr_data;
        @(posedge clk);
        #1;
        check("instr", instruccion, m_ins);
        check("adder", adder_pc, m_add);
        check("pc", pc, m_pc);
        check("halt", {31'd0, halt}, {31'd0, m_halted});
    endtask

    function automatic logic [31:0] init_word(input int unsigned i);
        case (i)
            0: return 32'h2001_0005;
            1: return 32'h2002_0007;
            2: return 32'h0022_1820;
            3: return HALTW;
            4: return 32'h2222_2222;
            8: return 32'h3333_3333;
            16: return 32'h1111_1111;
            32: return HALTW;
            default: return 32'h0000_0000;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 'x;
        m_pc = 0; m_ins = 0; m_add = 0; m_halted = 0;

        // Load the program while held in reset
        idle();
        rst = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_addr = NBA'(i); wr_data = init_word(i);
            cycle();
        end
        idle();
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instruccion, 32'h0);
        check("rst_halt", {31'd0, halt}, 32'd0);

        // Test 1: straight-line fetch ending in HALT
        cycle(); check("t1_i0", instruccion, 32'h2001_0005); check("t1_a0", adder_pc, 32'd4);
        cycle(); check("t1_i1", instruccion, 32'h2002_0007); check("t1_a1", adder_pc, 32'd8);
        cycle(); check("t1_i2", instruccion, 32'h0022_1820); check("t1_a2", adder_pc, 32'd12);
        cycle(); check("t1_i3", instruccion, HALTW); check("t1_a3", adder_pc, 32'd16);
        check("t1_halt", {31'd0, halt}, 32'd1); check("t1_pc", pc, 32'hC);
        cycle(); check("t1_nop", instruccion, 32'h0); check("t1_pch", pc, 32'hC);
        cycle();

        // Test 2: stall at pc=8
        br = 1'b1; br_addr = 32'h0; cycle(); idle();
        cycle(); cycle();
        check("t2_pc", pc, 32'h8);
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cycle();
            check("t2_spc", pc, 32'h8);
            check("t2_sins", instruccion, 32'h2002_0007);
            check("t2_sadd", adder_pc, 32'h8);
        end
        stall = 1'b0; cycle();
        check("t2_res", instruccion, 32'h0022_1820);

        // Test 3: branch at pc=0x10
        jmp = 1'b1; jmp_addr = 32'h10; cycle(); idle();
        check("t3_pc10", pc, 32'h10);
        br = 1'b1; br_addr = 32'h40; cycle(); idle();
        check("t3_bub", instruccion, 32'h0); check("t3_pc", pc, 32'h40);
        cycle();
        check("t3_tgt", instruccion, 32'h1111_1111);

        // Test 4: jump beats branch and stall
        jmp = 1'b1; jmp_addr = 32'h80; br = 1'b1; br_addr = 32'h40; stall = 1'b1;
        cycle(); idle();
        check("t4_pc", pc, 32'h80); check("t4_ins", instruccion, 32'h0);
        check("t4_add", adder_pc, 32'h0);

        // Test 5: halt then branch out
        cycle(); check("t5_halt", {31'd0, halt}, 32'd1);
        br = 1'b1; br_addr = 32'h20; cycle(); idle();
        check("t5_unhalt", {31'd0, halt}, 32'd0);
        cycle(); check("t5_tgt", instruccion, 32'h3333_3333);

        // Test 6: reset wins over disable; disable alone freezes
        rst = 1'b0; en = 1'b0; cycle(); idle();
        check("t6_pc", pc, 32'h0); check("t6_ins", instruccion, 32'h0);
        check("t6_add", adder_pc, 32'h0);
        cycle(); cycle();
        en = 1'b0; stall = 1'b0; br = 1'b1; br_addr = 32'h200;
        for (int k = 0; k < 3; k++) begin
            cycle(); check("t6_frz", pc, 32'h8);
        end
        idle();
        check("t6_mem", instruccion, 32'h2002_0007);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 99) != 0);
            en       = ($urandom_range(0, 9) != 0);
            stall    = ($urandom_range(0, 4) == 0);
            br       = ($urandom_range(0, 9) == 0);
            jmp      = ($urandom_range(0, 14) == 0);
            br_addr  = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h3FF);
            jmp_addr = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h3FF);
            wr_en    = ($urandom_range(0, 2) == 0);
            wr_addr  = NBA'($urandom);
            wr_data  = ($urandom_range(0, 9) == 0) ? (HALTW | ($urandom & 32'h03FF_FFFF)) : $urandom;
            if (wr_data[31:26] == 6'h3F && $urandom_range(0, 1) == 0) wr_data[31] = 1'b0;
            cycle();
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
